yutorina_pipe_ctrl: RTL

Pipeline controller for the Yutorina CPU. It sits beside the IF/ID/EX/MEM stages and produces every stall, flush and PC-redirect strobe. It resolves load-use hazards against the ID operand fetch, freezes the pipe during multi-cycle MEM bus accesses, redirects on ID branches, and sequences precise exception entry with EPC capture.

---
 rtl/yutorina_pipe_ctrl_pkg.sv | 40 ++++
 rtl/yutorina_pipe_ctrl_load_use_det.sv | 29 ++
 rtl/yutorina_pipe_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/yutorina_pipe_ctrl_pkg.sv
// Shared constants and types for the Yutorina pipeline controller.
// FSM encoding, exception vector default, MEM/EXP/GPR codes.
package yutorina_pipe_ctrl_pkg;

  localparam int GPR_ADDR_W  = 5;
  localparam int WORD_ADDR_W = 30;
  localparam int MEM_OP_W    = 2;
  localparam int EXP_W       = 3;

  localparam logic [WORD_ADDR_W-1:0] EXP_VECTOR_DEF = 30'h0000_0100;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NOP   = 2'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_STORE = 2'd2;

  localparam logic [EXP_W-1:0] EXP_NONE       = 3'd0;
  localparam logic [EXP_W-1:0] EXP_EXT_INT    = 3'd1;
  localparam logic [EXP_W-1:0] EXP_UNDEF_INSN = 3'd2;
  localparam logic [EXP_W-1:0] EXP_OVERFLOW   = 3'd3;
  localparam logic [EXP_W-1:0] EXP_MISS_ALIGN = 3'd4;
  localparam logic [EXP_W-1:0] EXP_TRAP       = 3'd5;
  localparam logic [EXP_W-1:0] EXP_PRV_VIO    = 3'd6;

  localparam logic [GPR_ADDR_W-1:0] GPR_ZERO = 5'd0;

  typedef enum logic [1:0] {
    CTRL_RUN       = 2'd0,
    CTRL_EXP_PEND  = 2'd1,
    CTRL_EXP_FLUSH = 2'd2
  } ctrl_state_e;

  function automatic logic gpr_hit(
    input logic                  used,
    input logic [GPR_ADDR_W-1:0] r_addr,
    input logic [GPR_ADDR_W-1:0] w_addr
  );
    return used && (r_addr == w_addr);
  endfunction

endpackage

// File: rtl/yutorina_pipe_ctrl_load_use_det.sv
// Load-use hazard compare between the EX load destination
// and the ID operand reads (pure combinational).
module yutorina_load_use_det
  import yutorina_pipe_ctrl_pkg::*;
(
  input  logic                  id_en_,
  input  logic [GPR_ADDR_W-1:0] id_r_addr1,
  input  logic [GPR_ADDR_W-1:0] id_r_addr2,
  input  logic                  id_r_used1,
  input  logic                  id_r_used2,
  input  logic                  ex_en_,
  input  logic [GPR_ADDR_W-1:0] ex_w_addr,
  input  logic [MEM_OP_W-1:0]   ex_mem_op,
  output logic                  hazard
);

  logic ex_load;
  logic rd_hit;

  // r0 is hardwired, so a load targeting it never blocks a reader
  assign ex_load = !ex_en_ && (ex_mem_op == MEM_OP_LOAD)
                && (ex_w_addr != GPR_ZERO);

  assign rd_hit = gpr_hit(id_r_used1, id_r_addr1, ex_w_addr)
               || gpr_hit(id_r_used2, id_r_addr2, ex_w_addr);

  assign hazard = !id_en_ && ex_load && rd_hit;

endmodule

// File: rtl/yutorina_pipe_ctrl.sv
// Yutorina pipeline controller: stalls, flushes, PC redirect, exception entry.
// Define YUTORINA_PERF_CNT_EN to add the stall_cnt performance counter.
module yutorina_pipe_ctrl
  import yutorina_pipe_ctrl_pkg::*;
#(
  parameter logic [WORD_ADDR_W-1:0] EXP_VECTOR = EXP_VECTOR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_en_,
  input  logic [GPR_ADDR_W-1:0]  id_r_addr1,
  input  logic [GPR_ADDR_W-1:0]  id_r_addr2,
  input  logic                   id_r_used1,
  input  logic                   id_r_used2,
  input  logic                   br_taken,
  input  logic [WORD_ADDR_W-1:0] br_addr,
  input  logic                   ex_en_,
  input  logic [GPR_ADDR_W-1:0]  ex_w_addr,
  input  logic [MEM_OP_W-1:0]    ex_mem_op,
  input  logic [EXP_W-1:0]       mem_exp_code,
  input  logic [WORD_ADDR_W-1:0] mem_pc,
  input  logic                   bus_busy,
  output logic                   if_stall,
  output logic                   id_stall,
  output logic                   ex_stall,
  output logic                   mem_stall,
  output logic                   if_flush,
  output logic                   id_flush,
  output logic                   ex_flush,
  output logic                   mem_flush,
  output logic                   pc_load,
  output logic [WORD_ADDR_W-1:0] new_pc,
  output logic [WORD_ADDR_W-1:0] epc,
  output logic [EXP_W-1:0]       exp_code
`ifdef YUTORINA_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  ctrl_state_e state;
  ctrl_state_e state_nx;
  logic        exp_ign;
  logic        exp_latch;
  logic        load_use;
  logic        exp_hit;
  logic        br_hit;

  yutorina_load_use_det u_lud (
    .id_en_     (id_en_),
    .id_r_addr1 (id_r_addr1),
    .id_r_addr2 (id_r_addr2),
    .id_r_used1 (id_r_used1),
    .id_r_used2 (id_r_used2),
    .ex_en_     (ex_en_),
    .ex_w_addr  (ex_w_addr),
    .ex_mem_op  (ex_mem_op),
    .hazard     (load_use)
  );

  // the cycle after a flush sees only bubbles, so its cause is stale
  assign exp_hit = (mem_exp_code != EXP_NONE) && !exp_ign;
  assign br_hit  = !id_en_ && br_taken;

  always_comb begin
    state_nx  = state;
    exp_latch = 1'b0;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    pc_load   = 1'b0;
    new_pc    = '0;
    if (!rst) begin
      unique case (state)
        CTRL_RUN: begin
          if (exp_hit || bus_busy) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
            if (exp_hit) begin
              state_nx  = bus_busy ? CTRL_EXP_PEND : CTRL_EXP_FLUSH;
              exp_latch = !bus_busy;
            end
          end else if (load_use) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
            id_flush = 1'b1;
          end else if (br_hit) begin
            pc_load  = 1'b1;
            new_pc   = br_addr;
            if_flush = 1'b1;
          end
        end
        CTRL_EXP_PEND: begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_stall  = 1'b1;
          mem_stall = 1'b1;
          if (!bus_busy) begin
            state_nx  = CTRL_EXP_FLUSH;
            exp_latch = 1'b1;
          end
        end
        CTRL_EXP_FLUSH: begin
          if_flush  = 1'b1;
          id_flush  = 1'b1;
          ex_flush  = 1'b1;
          mem_flush = 1'b1;
          pc_load   = 1'b1;
          new_pc    = EXP_VECTOR;
          state_nx  = CTRL_RUN;
        end
        default: state_nx = CTRL_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CTRL_RUN;
      exp_ign  <= 1'b0;
      epc      <= '0;
      exp_code <= EXP_NONE;
    end else begin
      state   <= state_nx;
      exp_ign <= (state == CTRL_EXP_FLUSH);
      if (exp_latch) begin
        epc      <= mem_pc;
        exp_code <= mem_exp_code;
      end
    end
  end

`ifdef YUTORINA_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (if_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
